// File: rtl/idct_pkg.sv
// Shared types, constants and helpers for the 8x8 IDCT engine.
package idct_pkg;

  typedef enum logic [2:0] {IDLE, LOAD, PASS1, PASS2, DRAIN} idct_state_t;

  localparam int BLK_N  = 8;
  localparam int BLK_SZ = 64;

  // C[k][n] = round(4096 * a(k) * cos((2n+1)k*pi/16))
  localparam logic signed [15:0] C_ROM [0:7][0:7] = '{
    '{ 16'sd1448,  16'sd1448,  16'sd1448,  16'sd1448,  16'sd1448,  16'sd1448,  16'sd1448,  16'sd1448},
    '{ 16'sd2009,  16'sd1703,  16'sd1138,  16'sd400,  -16'sd400,  -16'sd1138, -16'sd1703, -16'sd2009},
    '{ 16'sd1892,  16'sd784,  -16'sd784,  -16'sd1892, -16'sd1892, -16'sd784,   16'sd784,   16'sd1892},
    '{ 16'sd1703, -16'sd400,  -16'sd2009, -16'sd1138,  16'sd1138,  16'sd2009,  16'sd400,  -16'sd1703},
    '{ 16'sd1448, -16'sd1448, -16'sd1448,  16'sd1448,  16'sd1448, -16'sd1448, -16'sd1448,  16'sd1448},
    '{ 16'sd1138, -16'sd2009,  16'sd400,   16'sd1703, -16'sd1703, -16'sd400,   16'sd2009, -16'sd1138},
    '{ 16'sd784,  -16'sd1892,  16'sd1892, -16'sd784,  -16'sd784,   16'sd1892, -16'sd1892,  16'sd784},
    '{ 16'sd400,  -16'sd1138,  16'sd1703, -16'sd2009,  16'sd2009, -16'sd1703,  16'sd1138, -16'sd400}
  };

  // Sideband travelling with each MAC issue through the pipeline
  typedef struct packed {
    logic       first;
    logic       last;
    logic       pass2;
    logic [5:0] widx;
  } mac_meta_t;

  function automatic logic [7:0] clip8(input logic signed [63:0] v);
    if (v < 0)       return 8'd0;
    if (v > 64'sd255) return 8'hFF;
    return v[7:0];
  endfunction

endpackage

// File: rtl/idct_block_engine_if.sv
// Streaming in/out handshake bundle for idct_block_engine.
interface idct_block_engine_if #(parameter int COEF_W = 16);
  logic              in_valid;
  logic              in_ready;
  logic [COEF_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [7:0]        out_data;

  modport master (output in_valid, in_data, out_ready,
                  input  in_ready, out_valid, out_data);
  modport slave  (input  in_valid, in_data, out_ready,
                  output in_ready, out_valid, out_data);
endinterface

// File: rtl/idct_c_rom.sv
// NUM_MAC-wide combinational lookup of the IDCT basis constants C[k][n].
module idct_c_rom
  import idct_pkg::*;
#(
  parameter int NUM_MAC = 2,
  parameter int C_W     = 16
) (
  input  logic [NUM_MAC-1:0][2:0]     k_idx,
  input  logic [NUM_MAC-1:0][2:0]     n_idx,
  output logic [NUM_MAC-1:0][C_W-1:0] c_val
);
  for (genvar j = 0; j < NUM_MAC; j++) begin : g_lane
    assign c_val[j] = C_W'(C_ROM[k_idx[j]][n_idx[j]]);
  end
endmodule

// File: rtl/idct_block_engine.sv
// 8x8 2-D IDCT engine: load 64 S' samples, T = S'*C, S = C^T*T, clip, drain 64 pixels.
// Optional IDCT_CLIP_STATS_EN adds a saturating clip_count port.
module idct_block_engine
  import idct_pkg::*;
#(
  parameter int COEF_W      = 16,
  parameter int C_W         = 16,
  parameter int ACC_W       = 32,
  parameter int NUM_MAC     = 2,
  parameter int PASS1_SHIFT = 8,
  parameter int PASS2_SHIFT = 16
) (
  input  logic                 Clock,
  input  logic                 Resetn,
  idct_block_engine_if.slave   io,
  output logic                 busy
`ifdef IDCT_CLIP_STATS_EN
  ,output logic [15:0]         clip_count
`endif
);
  localparam int ISSUE    = 512 / NUM_MAC;
  localparam int LOG_MAC  = $clog2(NUM_MAC);
  localparam int PW       = ACC_W + C_W;
  localparam logic [9:0] LAST_CNT = 10'(ISSUE + 1);

  if (!(NUM_MAC == 1 || NUM_MAC == 2 || NUM_MAC == 4 || NUM_MAC == 8)) begin : g_bad_mac
    $error("NUM_MAC must be 1, 2, 4 or 8");
  end

  idct_state_t state_q, state_d;
  logic [6:0]  ld_cnt_q, ld_cnt_d;
  logic [9:0]  cnt_q, cnt_d;
  logic [6:0]  rd_idx_q, rd_idx_d;
  logic [6:0]  out_cnt_q, out_cnt_d;
  logic        in_ready_q, in_ready_d;
  logic        out_valid_q, out_valid_d;
  logic [7:0]  out_data_q, out_data_d;
  logic [COEF_W-1:0] s_buf_q [BLK_SZ];
  logic [COEF_W-1:0] s_buf_d [BLK_SZ];
  logic [ACC_W-1:0]  t_buf_q [BLK_SZ];
  logic [ACC_W-1:0]  t_buf_d [BLK_SZ];
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [15:0]       clip_cnt_q, clip_cnt_d;

  // MAC pipeline: vld_pipe[0] issue, [1] operands registered, [2] products registered
  logic [2:0]                     vld_pipe;
  logic [2:1]                     vld_pipe_q;
  mac_meta_t                      meta_iss, meta1_q, meta2_q;
  logic [NUM_MAC-1:0][ACC_W-1:0]  op_d, op_q;
  logic [NUM_MAC-1:0][C_W-1:0]    rom_c, c_q;
  logic [NUM_MAC-1:0][PW-1:0]     prod_d, prod_q;
  logic [NUM_MAC-1:0][2:0]        k_idx, n_idx;
  logic [8:0]                     pos;
  logic [5:0]                     elem;
  logic [2:0]                     kb;
  logic                           pass2;
  logic signed [ACC_W-1:0]        sum, pre;
  logic                           fire;
  logic                           unused_prod;

  idct_c_rom #(.NUM_MAC(NUM_MAC), .C_W(C_W)) u_c_rom (
    .k_idx (k_idx),
    .n_idx (n_idx),
    .c_val (rom_c)
  );

  // Issue stage: map the pass cycle counter to an output element and a k-slice
  always_comb begin
    pass2       = (state_q == PASS2);
    vld_pipe[0] = (state_q == PASS1 || state_q == PASS2) && (cnt_q < 10'(ISSUE));
    pos         = 9'({3'b0, cnt_q} << LOG_MAC);
    elem        = pos[8:3];
    kb          = pos[2:0];
    for (int j = 0; j < NUM_MAC; j++) begin
      k_idx[j] = kb + 3'(j);
      n_idx[j] = pass2 ? elem[5:3] : elem[2:0];
      op_d[j]  = pass2 ? t_buf_q[{k_idx[j], elem[2:0]}]
                       : ACC_W'($signed(s_buf_q[{elem[5:3], k_idx[j]}]));
    end
    meta_iss.first = (kb == 3'd0);
    meta_iss.last  = ((4'(kb) + 4'(NUM_MAC)) == 4'd8);
    meta_iss.pass2 = pass2;
    meta_iss.widx  = elem;
    vld_pipe[1]    = vld_pipe_q[1];
    vld_pipe[2]    = vld_pipe_q[2];
    for (int j = 0; j < NUM_MAC; j++)
      prod_d[j] = PW'($signed(op_q[j])) * PW'($signed(c_q[j]));
  end

  always_comb begin
    unused_prod = 1'b0;
    for (int j = 0; j < NUM_MAC; j++) unused_prod = unused_prod ^ (^prod_q[j][PW-1:ACC_W]);
  end

  always_comb begin
    state_d    = state_q;
    ld_cnt_d   = ld_cnt_q;
    cnt_d      = cnt_q;
    rd_idx_d   = rd_idx_q;
    out_cnt_d  = out_cnt_q;
    out_valid_d = out_valid_q;
    out_data_d = out_data_q;
    s_buf_d    = s_buf_q;
    t_buf_d    = t_buf_q;
    acc_d      = acc_q;
    clip_cnt_d = clip_cnt_q;
    fire       = 1'b0;
    sum        = '0;
    pre        = '0;

    // Accumulate stage; the last k-slice of an element writes back directly
    if (vld_pipe[2]) begin
      sum = meta2_q.first ? '0 : acc_q;
      for (int j = 0; j < NUM_MAC; j++) sum = sum + prod_q[j][ACC_W-1:0];
      acc_d = sum;
      if (meta2_q.last) begin
        if (!meta2_q.pass2) begin
          t_buf_d[meta2_q.widx] = sum >>> PASS1_SHIFT;
        end else begin
          pre = sum >>> PASS2_SHIFT;
          s_buf_d[meta2_q.widx] = COEF_W'(clip8(64'(pre)));
          if ((pre[ACC_W-1] || pre > $signed(ACC_W'(255))) && clip_cnt_q != 16'hFFFF)
            clip_cnt_d = clip_cnt_q + 16'd1;
        end
      end
    end

    case (state_q)
      IDLE: state_d = LOAD;
      LOAD: begin
        if (io.in_valid && in_ready_q) begin
          s_buf_d[ld_cnt_q[5:0]] = io.in_data;
          ld_cnt_d = ld_cnt_q + 7'd1;
        end
        if (ld_cnt_q == 7'd64) begin
          state_d  = PASS1;
          ld_cnt_d = '0;
          cnt_d    = '0;
        end
      end
      PASS1, PASS2: begin
        cnt_d = cnt_q + 10'd1;
        if (cnt_q == LAST_CNT) begin
          cnt_d     = '0;
          state_d   = (state_q == PASS1) ? PASS2 : DRAIN;
          rd_idx_d  = '0;
          out_cnt_d = '0;
        end
      end
      DRAIN: begin
        fire = out_valid_q && io.out_ready;
        if (fire) out_cnt_d = out_cnt_q + 7'd1;
        if (fire && out_cnt_q == 7'd63) begin
          state_d     = LOAD;
          out_valid_d = 1'b0;
        end else if (!out_valid_q || fire) begin
          if (rd_idx_q != 7'd64) begin
            out_valid_d = 1'b1;
            out_data_d  = s_buf_q[rd_idx_q[5:0]][7:0];
            rd_idx_d    = rd_idx_q + 7'd1;
          end else begin
            out_valid_d = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    in_ready_d = (state_d == LOAD) && (ld_cnt_d != 7'd64);
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q     <= IDLE;
      ld_cnt_q    <= '0;
      cnt_q       <= '0;
      rd_idx_q    <= '0;
      out_cnt_q   <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      s_buf_q     <= '{default: '0};
      t_buf_q     <= '{default: '0};
      acc_q       <= '0;
      clip_cnt_q  <= '0;
      vld_pipe_q  <= '0;
      meta1_q     <= '0;
      meta2_q     <= '0;
      op_q        <= '0;
      c_q         <= '0;
      prod_q      <= '0;
    end else begin
      state_q     <= state_d;
      ld_cnt_q    <= ld_cnt_d;
      cnt_q       <= cnt_d;
      rd_idx_q    <= rd_idx_d;
      out_cnt_q   <= out_cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      s_buf_q     <= s_buf_d;
      t_buf_q     <= t_buf_d;
      acc_q       <= acc_d;
      clip_cnt_q  <= clip_cnt_d;
      vld_pipe_q  <= vld_pipe[1:0];
      meta1_q     <= meta_iss;
      meta2_q     <= meta1_q;
      op_q        <= op_d;
      c_q         <= rom_c;
      prod_q      <= prod_d;
    end
  end

  assign io.in_ready  = in_ready_q;
  assign io.out_valid = out_valid_q;
  assign io.out_data  = out_data_q;
  assign busy         = (state_q != IDLE);
`ifdef IDCT_CLIP_STATS_EN
  assign clip_count   = clip_cnt_q;
`endif

endmodule

// File: tb/tb_idct_block_engine.sv
// Directed bench for idct_block_engine (NUM_MAC=2) with hand-computed pixel values.
module tb_idct_block_engine;
  localparam int NUM_MAC = 2;
  localparam int LAT     = 1 + 2 * (512 / NUM_MAC + 2) + 1;

  logic Clock = 1'b0;
  logic Resetn;
  logic busy;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
`ifdef IDCT_CLIP_STATS_EN
  logic [15:0] clip_count;
  int          exp_clip = 0;
`endif

  idct_block_engine_if #(.COEF_W(16)) io();

  idct_block_engine #(
    .COEF_W(16), .C_W(16), .ACC_W(32), .NUM_MAC(NUM_MAC),
    .PASS1_SHIFT(8), .PASS2_SHIFT(16)
  ) dut (
    .Clock  (Clock),
    .Resetn (Resetn),
    .io     (io.slave),
    .busy   (busy)
`ifdef IDCT_CLIP_STATS_EN
    ,.clip_count (clip_count)
`endif
  );

  always #5 Clock = ~Clock;
  always @(posedge Clock) cyc <= cyc + 1;

  logic [15:0] blk_in  [64];
  logic [7:0]  got     [64];
  logic [7:0]  ref_tbl [8];
  int          last_in_cyc;
  int          first_out_cyc;
  bit          tmo;

  task automatic clear_blk();
    for (int i = 0; i < 64; i++) blk_in[i] = '0;
  endtask

  // Called #1 after an edge; returns #1 after the edge that took the 64th sample
  task automatic send_block();
    int i = 0;
    int g = 0;
    bit acc;
    while (i < 64 && g < 2000) begin
      io.in_valid = 1'b1;
      io.in_data  = blk_in[i];
      acc = io.in_ready;
      @(posedge Clock); #1;
      if (acc) begin
        if (i == 63) last_in_cyc = cyc;
        i++;
      end
      g++;
    end
    io.in_valid = 1'b0;
    tmo = (i < 64);
  endtask

  task automatic collect();
    int n = 0;
    int g = 0;
    first_out_cyc = -1;
    io.out_ready = 1'b1;
    while (n < 64 && g < 3000) begin
      if (io.out_valid === 1'b1) begin
        if (first_out_cyc < 0) first_out_cyc = cyc;
        got[n] = io.out_data;
        n++;
      end
      @(posedge Clock); #1;
      g++;
    end
    tmo = (n < 64);
  endtask

  task automatic test_reset();
    repeat (3) @(posedge Clock);
    #1;
    checks++; if (io.in_ready !== 1'b0)  begin failures++; $display("FAIL reset_in_ready: got %b expected 0", io.in_ready); end
    checks++; if (io.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b expected 0", io.out_valid); end
    checks++; if (io.out_data !== 8'd0)  begin failures++; $display("FAIL reset_out_data: got %0d expected 0", io.out_data); end
    checks++; if (busy !== 1'b0)         begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
`ifdef IDCT_CLIP_STATS_EN
    checks++; if (clip_count !== 16'd0)  begin failures++; $display("FAIL reset_clip_count: got %0d expected 0", clip_count); end
`endif
    Resetn = 1'b1;
    repeat (2) @(posedge Clock);
    #1;
    checks++; if (busy !== 1'b1)        begin failures++; $display("FAIL load_busy: got %b expected 1", busy); end
    checks++; if (io.in_ready !== 1'b1) begin failures++; $display("FAIL load_in_ready: got %b expected 1", io.in_ready); end
  endtask

  // Single DC coefficient: every pixel equals pix; nclip pixels are clipped
  task automatic test_dc(input logic [15:0] dc, input logic [7:0] pix, input int nclip);
    clear_blk();
    blk_in[0] = dc;
    send_block();
    checks++; if (tmo) begin failures++; $display("FAIL dc_send_timeout: dc=%0d samples not all accepted", $signed(dc)); end
    collect();
    checks++; if (tmo) begin failures++; $display("FAIL dc_out_timeout: dc=%0d fewer than 64 pixels", $signed(dc)); end
    checks++;
    if (first_out_cyc - last_in_cyc !== LAT) begin
      failures++; $display("FAIL dc_latency: got %0d expected %0d", first_out_cyc - last_in_cyc, LAT);
    end
    for (int p = 0; p < 64; p++) begin
      checks++;
      if (got[p] !== pix) begin
        failures++; $display("FAIL dc_pixel dc=%0d p=%0d: got %0d expected %0d", $signed(dc), p, got[p], pix);
      end
    end
`ifdef IDCT_CLIP_STATS_EN
    exp_clip += nclip;
    checks++; if (clip_count !== 16'(exp_clip)) begin failures++; $display("FAIL dc_clip_count: got %0d expected %0d", clip_count, exp_clip); end
`else
    if (nclip < 0) $display("unexpected negative clip count");
`endif
  endtask

  // S'[0][1]=1024 varies along columns; S'[1][0]=1024 varies along rows
  task automatic test_pattern(input bit along_cols);
    clear_blk();
    if (along_cols) blk_in[1] = 16'd1024;
    else            blk_in[8] = 16'd1024;
    send_block();
    collect();
    checks++; if (tmo) begin failures++; $display("FAIL pattern_timeout: cols=%0d", along_cols); end
    for (int p = 0; p < 64; p++) begin
      logic [7:0] e;
      e = along_cols ? ref_tbl[p % 8] : ref_tbl[p / 8];
      checks++;
      if (got[p] !== e) begin
        failures++; $display("FAIL pattern_pixel cols=%0d p=%0d: got %0d expected %0d", along_cols, p, got[p], e);
      end
    end
`ifdef IDCT_CLIP_STATS_EN
    exp_clip += 32;
    checks++; if (clip_count !== 16'(exp_clip)) begin failures++; $display("FAIL pattern_clip_count: got %0d expected %0d", clip_count, exp_clip); end
`endif
  endtask

  task automatic test_backpressure();
    int  n = 0;
    int  g = 0;
    bit  stalled = 1'b0;
    logic [7:0] held = '0;
    clear_blk();
    blk_in[8] = 16'd1024;
    send_block();
    while (n < 64 && g < 5000) begin
      if (stalled) begin
        checks++;
        if (io.out_valid !== 1'b1 || io.out_data !== held) begin
          failures++; $display("FAIL bp_hold n=%0d: got valid=%b data=%0d expected valid=1 data=%0d", n, io.out_valid, io.out_data, held);
        end
      end
      io.out_ready = (g % 3 == 0);
      stalled = 1'b0;
      if (io.out_valid === 1'b1) begin
        if (io.out_ready) begin
          checks++;
          if (io.out_data !== ref_tbl[n / 8]) begin
            failures++; $display("FAIL bp_pixel p=%0d: got %0d expected %0d", n, io.out_data, ref_tbl[n / 8]);
          end
          n++;
        end else begin
          stalled = 1'b1;
          held    = io.out_data;
        end
      end
      @(posedge Clock); #1;
      g++;
    end
    io.out_ready = 1'b1;
    checks++; if (n != 64) begin failures++; $display("FAIL bp_timeout: got %0d pixels expected 64", n); end
`ifdef IDCT_CLIP_STATS_EN
    exp_clip += 32;
    checks++; if (clip_count !== 16'(exp_clip)) begin failures++; $display("FAIL bp_clip_count: got %0d expected %0d", clip_count, exp_clip); end
`endif
  endtask

  task automatic test_reset_mid_pass1();
    clear_blk();
    blk_in[0] = 16'd4000;
    send_block();
    repeat (40) @(posedge Clock);
    #1;
    checks++; if (busy !== 1'b1 || io.in_ready !== 1'b0) begin
      failures++; $display("FAIL mid_pass1_state: got busy=%b in_ready=%b expected busy=1 in_ready=0", busy, io.in_ready);
    end
    Resetn = 1'b0;
    #1;
    checks++; if (io.in_ready !== 1'b0)  begin failures++; $display("FAIL abort_in_ready: got %b expected 0", io.in_ready); end
    checks++; if (io.out_valid !== 1'b0) begin failures++; $display("FAIL abort_out_valid: got %b expected 0", io.out_valid); end
    checks++; if (io.out_data !== 8'd0)  begin failures++; $display("FAIL abort_out_data: got %0d expected 0", io.out_data); end
    checks++; if (busy !== 1'b0)         begin failures++; $display("FAIL abort_busy: got %b expected 0", busy); end
`ifdef IDCT_CLIP_STATS_EN
    checks++; if (clip_count !== 16'd0)  begin failures++; $display("FAIL abort_clip_count: got %0d expected 0", clip_count); end
    exp_clip = 0;
`endif
    @(posedge Clock); #1;
    Resetn = 1'b1;
    test_dc(16'd1025, 8'd128, 0);
  endtask

  initial begin
    Resetn       = 1'b0;
    io.in_valid  = 1'b0;
    io.in_data   = '0;
    io.out_ready = 1'b0;
    ref_tbl = '{8'd177, 8'd150, 8'd100, 8'd35, 8'd0, 8'd0, 8'd0, 8'd0};

    test_reset();
    test_dc(16'd1025, 8'd128, 0);
    test_dc(16'd1024, 8'd127, 0);
    test_dc(16'd4000, 8'd255, 64);
    test_dc(16'hFC18, 8'd0, 64);
    test_dc(16'd0, 8'd0, 0);
    test_pattern(1'b1);
    test_pattern(1'b0);
    test_backpressure();
    test_reset_mid_pass1();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
